sfifo_param: RTL and testbench
==============================

# sfifo_param

Parametrised single-clock synchronous FIFO: next generation of the team's FIFO block, configurable in data width and depth, with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It replaces the dual-clock FIFO wherever no clock crossing is required.

## Interface
- DW, 8, data word width in bits
- DEPTH, 16, number of entries; power of two, at least 2
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL; legal range 1..DEPTH
- AE_LVL, 2, almost_empty asserts when count <= AE_LVL; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush
- push  input  1  write request (push_e_t)
- data_in  input  DW  write data
- pop  input  1  read request (pop_e_t)
- data_out  output  DW  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LVL
- almost_empty  output  1  count <= AE_LVL
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation
- **Request acceptance**
  - A pop is accepted when pop && !empty.
  - A push is accepted when push && (!full || pop). A push on a full FIFO is accepted when it coincides with a pop.
- **Pointers**
  - Write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - An accepted push writes mem[wr_ptr] and then increments wr_ptr.
  - An accepted pop increments rd_ptr.
- **count**
  - +1 on push only, -1 on pop only.
  - Unchanged when both or neither request is accepted.
- **Flags**
  - full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- **Read data, FWFT=0**
  - data_out is a register loaded with mem[rd_ptr] on an accepted pop.
  - It holds its value otherwise.
- **Read data, FWFT=1**
  - data_out = mem[rd_ptr] while !empty.
  - data_out = 0 while empty.
  - pop acknowledges the word currently shown.
- **Sticky flags**
  - overflow is set on push && !accepted.
  - underflow is set on pop && empty.
  - Both hold until reset or clear.
- **clear**
  - Has priority over push and pop; requests in the same cycle are ignored and do not set the sticky flags.
  - Zeroes the pointers, count, overflow, underflow and data_out.
  - Memory contents are not cleared.
- **Parameter checks**
  - An illegal parameter combination (DEPTH not a power of two, AF_LVL or AE_LVL out of range) raises $error at elaboration.

## Timing
- **Reset (reset low, asynchronous)**
  - count=0, empty=1, full=0.
  - almost_empty=1, almost_full=0.
  - overflow=0, underflow=0, data_out=0.
  - Memory is not reset.
- **Reset release**
  - Deassertion is seen on a clock edge.
  - The first push is honoured on the first rising edge with reset high.
- **Flag latency**
  - A push accepted at edge k makes count, empty and the almost flags reflect it immediately after edge k.
- **Read latency, FWFT=0**
  - A word pushed at edge k can be popped at edge k+1 at the earliest.
  - data_out is valid after that pop edge.
- **Read latency, FWFT=1**
  - A word pushed at edge k appears on data_out immediately after edge k.
- **Simultaneous push and pop**
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: push accepted, pop rejected, underflow set, count becomes 1.
- **Reset mid-operation**
  - Asserting reset at any time forces all reset values immediately, independent of the clock.
  - Any in-flight write is lost.

## Structure
- **Shared package fifo_pkg**
  - push_e_t and pop_e_t enums.
  - Parametrised data_t.
  - Default constants DW_DEF and DEPTH_DEF.
- **Sub-module fifo_mem**
  - DEPTH x DW storage.
  - One synchronous write port and one asynchronous read port.
  - Instantiated once.
- **Top level**
  - Holds the pointers, count, flag decode, sticky flags, clear logic and the FWFT generate branch.

## Test plan
- Reset, then fill with 16 pushes of 0x00..0x0F (DW=8, DEPTH=16). Required:
  - count=16, full=1.
  - almost_full first asserts at count=14.
  - A 17th push sets overflow=1 with count unchanged.
- Drain 16 pops (FWFT=0). Required:
  - data_out sequence is 0x00..0x0F, each valid the cycle after its pop.
  - empty=1 after the last pop; almost_empty reasserts at count=2.
  - One further pop sets underflow=1.
- Wrap-around: 40 interleaved push/pop pairs with an occupancy of 3. Required:
  - Data order is preserved across pointer wrap.
  - count stays 3.
- Simultaneous push and pop on full and on empty. Required:
  - Full: count=16 and no overflow.
  - Empty: count=1, underflow=1, and the pushed word is read on the next pop.
- FWFT=1: push 0xA5 into an empty FIFO. Required:
  - data_out=0xA5 the cycle after the push, with no pop issued.
  - A pop returns data_out=0 and empty=1.
- Issue clear with push=1 at count=5 and overflow=1, then assert reset mid-burst. Required:
  - After clear: count=0, overflow=0, data_out=0, and the push is ignored.
  - After reset: all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: request encodings, default geometry and the
// default data word type used by the FIFO family.
package fifo_pkg;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  typedef logic [DW_DEF-1:0] data_t;

  typedef enum logic {PUSH_IDLE = 1'b0, PUSH_REQ = 1'b1} push_e_t;
  typedef enum logic {POP_IDLE  = 1'b0, POP_REQ  = 1'b1} pop_e_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk_i            write clock
//   we_i/waddr_i     write enable / address
//   wdata_i          write data
//   raddr_i/rdata_o  combinational read address / data
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DEPTH-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sfifo_param.sv
// Single-clock synchronous FIFO with programmable almost flags, occupancy
// count, sticky overflow/underflow, synchronous flush and optional
// first-word-fall-through read.
//   clk_i, rst_ni          clock, async active-low reset
//   clear_i                synchronous flush (wins over push/pop)
//   push_i, data_in_i      write request / data
//   pop_i, data_out_o      read request / data
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o  occupancy status
//   overflow_o, underflow_o  sticky rejected-request flags
module sfifo_param
  import fifo_pkg::*;
#(
  parameter  int DW     = DW_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int AF_LVL = DEPTH - 2,
  parameter  int AE_LVL = 2,
  parameter  int FWFT   = 0,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_in_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_out_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          underflow_o
);
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sfifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_bad_af
    $error("sfifo_param: AF_LVL out of range 1..DEPTH");
  end
  if ((AE_LVL < 0) || (AE_LVL > DEPTH - 1)) begin : g_bad_ae
    $error("sfifo_param: AE_LVL out of range 0..DEPTH-1");
  end

  push_e_t push_e;
  pop_e_t  pop_e;
  assign push_e = push_e_t'(push_i);
  assign pop_e  = pop_e_t'(pop_i);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_acc, pop_acc;
  logic [DW-1:0] rdata;

  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AF_LVL));
  assign almost_empty_o = (count_q <= CW'(AE_LVL));
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  // A pop frees a slot in the same edge, so a full FIFO still takes a push
  // that coincides with it.
  assign pop_acc  = (pop_e == POP_REQ) && !empty_o;
  assign push_acc = (push_e == PUSH_REQ) && (!full_o || (pop_e == POP_REQ));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | ((push_e == PUSH_REQ) && !push_acc);
    unf_d    = unf_q | ((pop_e == POP_REQ) && empty_o);
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_acc && !clear_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (FWFT == 0) begin : g_reg_rd
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      dout_q <= '0;
      else if (clear_i) dout_q <= '0;
      else if (pop_acc) dout_q <= rdata;
    end
    assign data_out_o = dout_q;
  end else begin : g_fwft_rd
    // Head word is shown directly; forced to zero so an empty FIFO never
    // exposes stale memory.
    assign data_out_o = empty_o ? '0 : rdata;
  end
endmodule

// File: tb/tb_sfifo_param.sv
module tb_sfifo_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: registered read
  logic       clr = 0, push = 0, pop = 0;
  logic [7:0] din = 0, dout;
  logic       full, empty, af, ae, ovf, unf;
  logic [4:0] cnt;

  // instance B: first-word-fall-through
  logic       clr_b = 0, push_b = 0, pop_b = 0;
  logic [7:0] din_b = 0, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] cnt_b;

  sfifo_param #(.DW(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .push_i(push), .data_in_i(din),
    .pop_i(pop), .data_out_o(dout), .full_o(full), .empty_o(empty),
    .almost_full_o(af), .almost_empty_o(ae), .count_o(cnt),
    .overflow_o(ovf), .underflow_o(unf));

  sfifo_param #(.DW(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_b), .push_i(push_b), .data_in_i(din_b),
    .pop_i(pop_b), .data_out_o(dout_b), .full_o(full_b), .empty_o(empty_b),
    .almost_full_o(af_b), .almost_empty_o(ae_b), .count_o(cnt_b),
    .overflow_o(ovf_b), .underflow_o(unf_b));

  int total = 0, bad = 0, step = 0;

  // reference model for instance A
  logic [7:0] sb[$];
  int         m_cnt = 0;
  bit         m_ovf = 0, m_unf = 0;
  logic [7:0] m_dout = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d obs=%0h exp=%0h", tag, step, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",  32'(cnt),   32'(m_cnt));
    chk("full",   32'(full),  32'(m_cnt == 16));
    chk("empty",  32'(empty), 32'(m_cnt == 0));
    chk("afull",  32'(af),    32'(m_cnt >= 14));
    chk("aempty", 32'(ae),    32'(m_cnt <= 2));
    chk("ovf",    32'(ovf),   32'(m_ovf));
    chk("unf",    32'(unf),   32'(m_unf));
    chk("dout",   32'(dout),  32'(m_dout));
  endtask

  task automatic model_reset();
    sb.delete(); m_cnt = 0; m_ovf = 0; m_unf = 0; m_dout = 0;
  endtask

  // One clock on instance A; the queue holds words in expected pop order.
  task automatic cyc(input bit ps, input logic [7:0] d, input bit pp, input bit cl = 1'b0);
    bit wa, pa;
    step++;
    push = ps; din = d; pop = pp; clr = cl;
    pa = pp && (m_cnt > 0);
    wa = ps && ((m_cnt < 16) || pp);
    @(posedge clk); #1;
    push = 0; pop = 0; clr = 0;
    if (cl) model_reset();
    else begin
      if (ps && !wa) m_ovf = 1;
      if (pp && m_cnt == 0) m_unf = 1;
      if (pa) begin m_dout = sb.pop_front(); m_cnt--; end
      if (wa) begin sb.push_back(d); m_cnt++; end
    end
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset values, asynchronously before any clock edge
    #2;
    check_all();
    chk("b_dout_rst",  32'(dout_b),  32'h0);
    chk("b_empty_rst", 32'(empty_b), 32'h1);
    #10 rst_n = 1'b1;   // released between edges; next edge takes the first push

    // fill 0x00..0x0F, then a rejected 17th push
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hEE, 0);
    // drain in order, then a rejected pop
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 1);  // flush sticky flags

    // wrap-around at occupancy 3
    for (int i = 0; i < 3; i++)  cyc(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'h50 + i), 1);
    for (int i = 0; i < 3; i++)  cyc(0, 8'h00, 1);

    // simultaneous push/pop on full: no overflow
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0);
    cyc(1, 8'hC0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    // simultaneous push/pop on empty: underflow, word kept
    cyc(1, 8'h77, 1);
    cyc(0, 8'h00, 1);

    // clear with push at count=5 and overflow=1
    for (int i = 0; i < 17; i++) cyc(1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1);
    chk("pre_clear_cnt", 32'(cnt), 32'd5);
    chk("pre_clear_ovf", 32'(ovf), 32'd1);
    cyc(1, 8'hDD, 0, 1);
    cyc(0, 8'h00, 0);

    // reset asserted mid-burst, between edges
    cyc(1, 8'h31, 0);
    cyc(1, 8'h32, 0);
    cyc(0, 8'h00, 1);
    step++;
    push = 1; din = 8'h39;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1; push = 0;
    @(posedge clk); #1;
    check_all();
    cyc(1, 8'h33, 0);
    cyc(0, 8'h00, 1);

    // FWFT instance
    step++;
    chk("b_dout_idle", 32'(dout_b), 32'h0);
    push_b = 1; din_b = 8'hA5;
    @(posedge clk); #1; push_b = 0;
    chk("b_dout_push", 32'(dout_b),  32'hA5);
    chk("b_empty_0",   32'(empty_b), 32'h0);
    chk("b_cnt_1",     32'(cnt_b),   32'h1);
    @(posedge clk); #1;
    chk("b_dout_hold", 32'(dout_b), 32'hA5);
    pop_b = 1;
    @(posedge clk); #1; pop_b = 0;
    chk("b_dout_pop",  32'(dout_b),  32'h0);
    chk("b_empty_1",   32'(empty_b), 32'h1);
    push_b = 1; din_b = 8'hB1;
    @(posedge clk); #1; din_b = 8'hB2;
    @(posedge clk); #1; push_b = 0;
    chk("b_head1", 32'(dout_b), 32'hB1);
    pop_b = 1;
    @(posedge clk); #1; pop_b = 0;
    chk("b_head2", 32'(dout_b), 32'hB2);
    chk("b_cnt",   32'(cnt_b),  32'h1);
    chk("b_unf",   32'(unf_b),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
